// File: rtl/latency_mem.sv
// latency_mem: byte-addressed little-endian memory with a valid/ready request port,
// a fixed-latency one-cycle response strobe, range checking and completion counters.
`default_nettype none

module latency_mem #(
    parameter int    DEPTH_BYTES = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count,
    output logic [31:0] o_err_count
);

    localparam int          AW        = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;
    localparam logic [31:0] MAX_ADDR  = 32'(DEPTH_BYTES - 4);
    localparam logic [3:0]  WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, enter_resp;

    logic [31:0] lat_addr, lat_wdata;
    logic        lat_wen;
    logic [3:0]  lat_mask;

    logic [31:0] acc_addr, acc_wdata, rd_word;
    logic        acc_wen, acc_err;
    logic [3:0]  acc_mask;
    logic [AW-1:0] idx [4];

    logic [7:0]  mem [DEPTH_BYTES];

    assign o_req_ready = (state != WAIT);
    assign o_rsp_valid = (state == RESP);
    assign accept      = i_req_valid & o_req_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == RESP);

    // With single-cycle latency the access happens on the acceptance edge itself,
    // so the operands come straight from the request port rather than the latch.
    assign acc_addr  = (LATENCY == 1) ? i_req_addr  : lat_addr;
    assign acc_wen   = (LATENCY == 1) ? i_req_wen   : lat_wen;
    assign acc_wdata = (LATENCY == 1) ? i_req_wdata : lat_wdata;
    assign acc_mask  = (LATENCY == 1) ? i_req_mask  : lat_mask;
    assign acc_err   = (acc_addr > MAX_ADDR);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = acc_addr[AW-1:0] + AW'(k);
        end
    end

    assign rd_word = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_addr    <= 32'd0;
            lat_wen     <= 1'b0;
            lat_wdata   <= 32'd0;
            lat_mask    <= 4'd0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
            o_rd_count  <= 32'd0;
            o_wr_count  <= 32'd0;
            o_err_count <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_addr  <= i_req_addr;
                lat_wen   <= i_req_wen;
                lat_wdata <= i_req_wdata;
                lat_mask  <= i_req_mask;
            end
            if (enter_resp) begin
                o_rsp_rdata <= (acc_err || acc_wen) ? 32'd0 : rd_word;
                o_rsp_err   <= acc_err;
            end
            // Counting on the RESP exit uses the response being retired, not a new one.
            if (state == RESP) begin
                if (o_rsp_err) begin
                    o_err_count <= o_err_count + 32'd1;
                end else if (lat_wen) begin
                    o_wr_count <= o_wr_count + 32'd1;
                end else begin
                    o_rd_count <= o_rd_count + 32'd1;
                end
            end
        end
    end

    // Memory has no reset; a write lands only on a RESP-entry edge outside reset.
    always_ff @(posedge i_clk) begin
        if (enter_resp && !i_rst && acc_wen && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_mask[k]) begin
                    mem[idx[k]] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire
